// File: rtl/gesture_pkg.sv
// ==== gesture_pkg: shared encodings and band thresholds for the gesture decoder ====
// ==== rev 1.0 ====
`default_nettype none

package gesture_pkg;

  typedef enum logic [1:0] {
    CMD_NONE  = 2'd0,
    CMD_PAUSE = 2'd1,
    CMD_PLAY  = 2'd2,
    CMD_NEXT  = 2'd3
  } gesture_cmd_e;

  // invalid marks an out-of-band frame; cls then reads as CMD_NONE
  typedef struct packed {
    logic         invalid;
    gesture_cmd_e cls;
  } gesture_class_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CAND = 2'd1,
    ST_FIRE = 2'd2,
    ST_HOLD = 2'd3
  } gesture_state_e;

  localparam int unsigned C_PAUSE_LOW_DEF      = 18;
  localparam int unsigned C_PLAY_LOW_DEF       = 29;
  localparam int unsigned C_NEXT_LOW_DEF       = 34;
  localparam int unsigned C_NEXT_HIGH_DEF      = 45;
  localparam int unsigned C_RATIO_NEXT_MAX_DEF = 80;
  localparam int unsigned C_STABLE_FRAMES_DEF  = 3;
  localparam int unsigned C_RELEASE_FRAMES_DEF = 2;

endpackage

`default_nettype wire

// File: rtl/gesture_cmd_decoder_if.sv
// ==== gesture_cmd_decoder_if: frame metrics in, playback command handshake out ====
// ==== rev 1.0 ====
`default_nettype none

interface gesture_cmd_decoder_if;

  logic        vga_vsync;
  logic [6:0]  pout;
  logic [13:0] ratio;
  logic [1:0]  cmd;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cur_class;
  logic [1:0]  state_out;

  modport master (
    input  vga_vsync, pout, ratio, cmd_ready,
    output cmd, cmd_valid, cur_class, state_out
  );

  modport slave (
    output vga_vsync, pout, ratio, cmd_ready,
    input  cmd, cmd_valid, cur_class, state_out
  );

endinterface

`default_nettype wire

// File: rtl/vsync_edge_det.sv
// ==== vsync_edge_det: one-cycle frame strobe on the falling edge of vsync ====
// ==== rev 1.0 ====
`default_nettype none

module vsync_edge_det (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic vsync_i,
  output logic frame_tick_o
);

  logic vsync_q;

  // Clearing to 0 keeps a vsync that is low out of reset from faking a frame
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      vsync_q <= 1'b0;
    end else begin
      vsync_q <= vsync_i;
    end
  end

  assign frame_tick_o = vsync_q & ~vsync_i;

endmodule

`default_nettype wire

// File: rtl/gesture_cmd_decoder.sv
// ==== gesture_cmd_decoder: frame-debounced hand gesture to one-shot playback command ====
// ==== rev 1.0 ====
`default_nettype none

module gesture_cmd_decoder
  import gesture_pkg::*;
#(
  parameter int unsigned PAUSE_LOW      = C_PAUSE_LOW_DEF,
  parameter int unsigned PLAY_LOW       = C_PLAY_LOW_DEF,
  parameter int unsigned NEXT_LOW       = C_NEXT_LOW_DEF,
  parameter int unsigned NEXT_HIGH      = C_NEXT_HIGH_DEF,
  parameter int unsigned RATIO_NEXT_MAX = C_RATIO_NEXT_MAX_DEF,
  parameter int unsigned STABLE_FRAMES  = C_STABLE_FRAMES_DEF,
  parameter int unsigned RELEASE_FRAMES = C_RELEASE_FRAMES_DEF
) (
  input  logic                  clk25,
  input  logic                  rst_n,
  gesture_cmd_decoder_if.master bus
);

  localparam logic [6:0]  C_PAUSE_LOW = 7'(PAUSE_LOW);
  localparam logic [6:0]  C_PLAY_LOW  = 7'(PLAY_LOW);
  localparam logic [6:0]  C_NEXT_LOW  = 7'(NEXT_LOW);
  localparam logic [6:0]  C_NEXT_HIGH = 7'(NEXT_HIGH);
  localparam logic [13:0] C_RATIO_MAX = 14'(RATIO_NEXT_MAX);
  localparam logic [3:0]  C_STABLE    = 4'(STABLE_FRAMES);
  localparam logic [3:0]  C_RELEASE   = 4'(RELEASE_FRAMES);

  logic           frame_tick;
  gesture_class_t frame_cls;
  logic           is_hand;
  logic           is_none;

  gesture_state_e state_q;
  gesture_cmd_e   cand_q;
  gesture_cmd_e   cmd_q;
  gesture_cmd_e   cur_class_q;
  logic           cmd_valid_q;
  logic [3:0]     stab_cnt_q, stab_cnt_d;
  logic [3:0]     rel_cnt_q, rel_cnt_d;

  vsync_edge_det u_vsync_edge_det (
    .clk_i        (clk25),
    .rst_ni       (rst_n),
    .vsync_i      (bus.vga_vsync),
    .frame_tick_o (frame_tick)
  );

  always_comb begin
    frame_cls.invalid = 1'b0;
    frame_cls.cls     = CMD_NONE;
    if (bus.pout < C_PAUSE_LOW) begin
      frame_cls.cls = CMD_NONE;
    end else if (bus.pout < C_PLAY_LOW) begin
      frame_cls.cls = CMD_PAUSE;
    end else if (bus.pout < C_NEXT_LOW) begin
      frame_cls.cls = CMD_PLAY;
    end else if (bus.pout <= C_NEXT_HIGH) begin
      frame_cls.cls = (bus.ratio <= C_RATIO_MAX) ? CMD_NEXT : CMD_PLAY;
    end else begin
      frame_cls.invalid = 1'b1;
    end
  end

  assign is_hand    = !frame_cls.invalid && (frame_cls.cls != CMD_NONE);
  assign is_none    = !frame_cls.invalid && (frame_cls.cls == CMD_NONE);
  assign stab_cnt_d = (stab_cnt_q == 4'hF) ? 4'hF : stab_cnt_q + 4'd1;
  assign rel_cnt_d  = (rel_cnt_q == 4'hF) ? 4'hF : rel_cnt_q + 4'd1;

  always_ff @(posedge clk25) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cand_q      <= CMD_NONE;
      cmd_q       <= CMD_NONE;
      cur_class_q <= CMD_NONE;
      cmd_valid_q <= 1'b0;
      stab_cnt_q  <= 4'd0;
      rel_cnt_q   <= 4'd0;
    end else begin
      if (frame_tick) begin
        cur_class_q <= frame_cls.cls;
      end
      case (state_q)
        ST_IDLE: begin
          if (frame_tick && is_hand) begin
            cand_q     <= frame_cls.cls;
            stab_cnt_q <= 4'd1;
            state_q    <= (C_STABLE == 4'd1) ? ST_FIRE : ST_CAND;
          end
        end
        ST_CAND: begin
          if (frame_tick) begin
            if (is_hand && (frame_cls.cls == cand_q)) begin
              stab_cnt_q <= stab_cnt_d;
              if (stab_cnt_d >= C_STABLE) begin
                state_q <= ST_FIRE;
              end
            end else if (is_hand) begin
              cand_q     <= frame_cls.cls;
              stab_cnt_q <= 4'd1;
            end else begin
              stab_cnt_q <= 4'd0;
              state_q    <= ST_IDLE;
            end
          end
        end
        // First FIRE cycle raises valid; frame ticks are ignored until accepted
        ST_FIRE: begin
          if (!cmd_valid_q) begin
            cmd_q       <= cand_q;
            cmd_valid_q <= 1'b1;
          end else if (bus.cmd_ready) begin
            cmd_valid_q <= 1'b0;
            stab_cnt_q  <= 4'd0;
            rel_cnt_q   <= 4'd0;
            state_q     <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (frame_tick) begin
            if (is_none) begin
              if (rel_cnt_d >= C_RELEASE) begin
                rel_cnt_q <= 4'd0;
                state_q   <= ST_IDLE;
              end else begin
                rel_cnt_q <= rel_cnt_d;
              end
            end else begin
              rel_cnt_q <= 4'd0;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.cmd       = cmd_q;
  assign bus.cmd_valid = cmd_valid_q;
  assign bus.cur_class = cur_class_q;
  assign bus.state_out = state_q;

endmodule

`default_nettype wire

// File: tb/tb_gesture_cmd_decoder.sv
// ==== tb_gesture_cmd_decoder: directed scenarios plus randomized frames against a run-length model ====
// ==== rev 1.0 ====
`default_nettype none
`timescale 1ns/1ps

module tb_gesture_cmd_decoder;

  localparam int STABLE  = 3;
  localparam int RELEASE = 2;

  logic clk25 = 1'b0;
  logic rst_n = 1'b0;

  gesture_cmd_decoder_if bus ();

  gesture_cmd_decoder #(
    .PAUSE_LOW      (18),
    .PLAY_LOW       (29),
    .NEXT_LOW       (34),
    .NEXT_HIGH      (45),
    .RATIO_NEXT_MAX (80),
    .STABLE_FRAMES  (STABLE),
    .RELEASE_FRAMES (RELEASE)
  ) dut (
    .clk25 (clk25),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #20 clk25 = ~clk25;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int tick_cyc = 0;
  int xfer_cmd[$];
  int xfer_cyc[$];
  logic       prev_valid = 1'b0;
  logic [1:0] prev_cmd   = 2'd0;

  always @(posedge clk25) cyc <= cyc + 1;

  // Handshake log and cmd-stability watch, sampled mid-low-phase after inputs settle
  always begin
    @(negedge clk25);
    #2;
    if (rst_n === 1'b1) begin
      if (bus.cmd_valid === 1'b1 && bus.cmd_ready === 1'b1) begin
        xfer_cmd.push_back(int'(bus.cmd));
        xfer_cyc.push_back(cyc);
      end
      if (prev_valid && bus.cmd_valid === 1'b1) begin
        total++;
        if (bus.cmd !== prev_cmd) begin
          bad++;
          $display("FAIL cmd_stable: got %0d want %0d", bus.cmd, prev_cmd);
        end
      end
      prev_valid = (bus.cmd_valid === 1'b1);
      prev_cmd   = bus.cmd;
    end else begin
      prev_valid = 1'b0;
    end
  end

  // Reference model: class bands, then run-length debounce and release counting
  bit m_armed    = 1'b1;
  int m_run_cls  = 0;
  int m_run_len  = 0;
  int m_none_run = 0;

  function automatic int ref_class(input int p, input int r);
    if (p < 18) return 0;
    if (p < 29) return 1;
    if (p < 34) return 2;
    if (p <= 45) return (r <= 80) ? 3 : 2;
    return 4;
  endfunction

  function automatic int model_frame(input int c);
    int fired = -1;
    if (m_armed) begin
      if (c >= 1 && c <= 3) begin
        if (m_run_len > 0 && c == m_run_cls) m_run_len++;
        else begin
          m_run_cls = c;
          m_run_len = 1;
        end
        if (m_run_len >= STABLE) begin
          fired      = m_run_cls;
          m_armed    = 1'b0;
          m_none_run = 0;
          m_run_len  = 0;
        end
      end else begin
        m_run_len = 0;
      end
    end else begin
      if (c == 0) begin
        m_none_run++;
        if (m_none_run >= RELEASE) begin
          m_armed   = 1'b1;
          m_run_len = 0;
        end
      end else begin
        m_none_run = 0;
      end
    end
    return fired;
  endfunction

  task automatic send_frame(input logic [6:0] p, input logic [13:0] r);
    @(negedge clk25);
    bus.pout      = p;
    bus.ratio     = r;
    bus.vga_vsync = 1'b0;
    tick_cyc      = cyc;
    repeat (2) @(negedge clk25);
    bus.vga_vsync = 1'b1;
    repeat (8) @(negedge clk25);
  endtask

  task automatic go_idle();
    repeat (RELEASE) send_frame(7'd0, 14'd0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk25);
      total++;
      if ({bus.cmd_valid, bus.cmd, bus.state_out} !== 5'b0) begin
        bad++;
        $display("FAIL reset_hold[%0d]: got valid=%b cmd=%0d state=%0d want 0", i, bus.cmd_valid, bus.cmd, bus.state_out);
      end
      bus.vga_vsync = 1'($urandom);
      bus.pout      = 7'($urandom);
      bus.ratio     = 14'($urandom);
      bus.cmd_ready = 1'($urandom);
    end
    rst_n         = 1'b1;
    bus.vga_vsync = 1'b1;
    bus.pout      = 7'd0;
    bus.cmd_ready = 1'b1;
    @(negedge clk25);
    total++;
    if ({bus.cmd_valid, bus.cmd, bus.state_out, bus.cur_class} !== 7'b0) begin
      bad++;
      $display("FAIL reset_release: got valid=%b cmd=%0d state=%0d cls=%0d want 0", bus.cmd_valid, bus.cmd, bus.state_out, bus.cur_class);
    end
  endtask

  task automatic test_debounce();
    int n0 = xfer_cmd.size();
    int t3;
    repeat (3) send_frame(7'd30, 14'($urandom));
    t3 = tick_cyc;
    total++;
    if (xfer_cmd.size() != n0 + 1) begin
      bad++;
      $display("FAIL debounce_count: got %0d want %0d", xfer_cmd.size() - n0, 1);
    end else begin
      total++;
      if (xfer_cmd[n0] != 2) begin
        bad++;
        $display("FAIL debounce_cmd: got %0d want 2", xfer_cmd[n0]);
      end
      total++;
      if (xfer_cyc[n0] != t3 + 2) begin
        bad++;
        $display("FAIL debounce_latency: got %0d want %0d", xfer_cyc[n0] - t3, 2);
      end
    end
    total++;
    if (bus.cur_class !== 2'd2) begin
      bad++;
      $display("FAIL debounce_class: got %0d want 2", bus.cur_class);
    end
    repeat (5) send_frame(7'd30, 14'($urandom));
    total++;
    if (xfer_cmd.size() != n0 + 1 || bus.state_out !== 2'd3) begin
      bad++;
      $display("FAIL held_no_refire: got xfers=%0d state=%0d want 1 and 3", xfer_cmd.size() - n0, bus.state_out);
    end
  endtask

  task automatic test_next_ratio();
    int n0;
    go_idle();
    total++;
    if (bus.state_out !== 2'd0) begin
      bad++;
      $display("FAIL next_idle: got %0d want 0", bus.state_out);
    end
    n0 = xfer_cmd.size();
    repeat (3) send_frame(7'd40, 14'd50);
    total++;
    if (xfer_cmd.size() != n0 + 1 || xfer_cmd[xfer_cmd.size()-1] != 3) begin
      bad++;
      $display("FAIL next_cmd: got xfers=%0d last=%0d want 1 and 3", xfer_cmd.size() - n0, xfer_cmd.size() ? xfer_cmd[xfer_cmd.size()-1] : -1);
    end
    repeat (2) send_frame(7'd5, 14'd150);
    total++;
    if (bus.state_out !== 2'd0) begin
      bad++;
      $display("FAIL next_release: got %0d want 0", bus.state_out);
    end
    repeat (3) send_frame(7'd40, 14'd150);
    total++;
    if (xfer_cmd.size() != n0 + 2 || xfer_cmd[xfer_cmd.size()-1] != 2) begin
      bad++;
      $display("FAIL ratio_gate: got xfers=%0d last=%0d want 2 and 2", xfer_cmd.size() - n0, xfer_cmd.size() ? xfer_cmd[xfer_cmd.size()-1] : -1);
    end
  endtask

  task automatic test_class_change();
    int n0;
    go_idle();
    n0 = xfer_cmd.size();
    send_frame(7'd20, 14'd0);
    send_frame(7'd20, 14'd0);
    send_frame(7'd31, 14'd0);
    send_frame(7'd31, 14'd0);
    total++;
    if (xfer_cmd.size() != n0 || bus.state_out !== 2'd1) begin
      bad++;
      $display("FAIL change_pending: got xfers=%0d state=%0d want 0 and 1", xfer_cmd.size() - n0, bus.state_out);
    end
    send_frame(7'd31, 14'd0);
    total++;
    if (xfer_cmd.size() != n0 + 1 || xfer_cmd[n0] != 2 || xfer_cyc[n0] != tick_cyc + 2) begin
      bad++;
      $display("FAIL change_fire: got xfers=%0d want 1 PLAY at tick+2", xfer_cmd.size() - n0);
    end
  endtask

  task automatic test_backpressure();
    int n0;
    go_idle();
    bus.cmd_ready = 1'b0;
    n0 = xfer_cmd.size();
    repeat (3) send_frame(7'd20, 14'($urandom));
    for (int i = 0; i < 100; i++) begin
      send_frame(7'($urandom), 14'($urandom));
      total++;
      if (bus.cmd_valid !== 1'b1 || bus.cmd !== 2'd1 || bus.state_out !== 2'd2) begin
        bad++;
        $display("FAIL bp_hold[%0d]: got valid=%b cmd=%0d state=%0d want 1 1 2", i, bus.cmd_valid, bus.cmd, bus.state_out);
      end
    end
    bus.cmd_ready = 1'b1;
    @(negedge clk25);
    total++;
    if (bus.cmd_valid !== 1'b0 || bus.state_out !== 2'd3 || xfer_cmd.size() != n0 + 1) begin
      bad++;
      $display("FAIL bp_release: got valid=%b state=%0d xfers=%0d want 0 3 1", bus.cmd_valid, bus.state_out, xfer_cmd.size() - n0);
    end
  endtask

  task automatic test_invalid_release();
    int n0;
    logic [6:0] pat[4] = '{7'd0, 7'd20, 7'd0, 7'd0};
    logic [1:0] st_exp[4] = '{2'd3, 2'd3, 2'd3, 2'd0};
    go_idle();
    n0 = xfer_cmd.size();
    for (int i = 0; i < 6; i++) begin
      send_frame(7'd60, 14'($urandom));
      total++;
      if (bus.state_out !== 2'd0 || bus.cur_class !== 2'd0) begin
        bad++;
        $display("FAIL invalid_idle[%0d]: got state=%0d cls=%0d want 0 0", i, bus.state_out, bus.cur_class);
      end
    end
    send_frame(7'd20, 14'd0);
    send_frame(7'd20, 14'd0);
    send_frame(7'd60, 14'd0);
    send_frame(7'd20, 14'd0);
    send_frame(7'd20, 14'd0);
    total++;
    if (xfer_cmd.size() != n0 || bus.state_out !== 2'd1) begin
      bad++;
      $display("FAIL invalid_resets: got xfers=%0d state=%0d want 0 1", xfer_cmd.size() - n0, bus.state_out);
    end
    send_frame(7'd20, 14'd0);
    total++;
    if (xfer_cmd.size() != n0 + 1 || xfer_cmd[n0] != 1) begin
      bad++;
      $display("FAIL invalid_then_fire: got xfers=%0d want 1 PAUSE", xfer_cmd.size() - n0);
    end
    for (int i = 0; i < 4; i++) begin
      send_frame(pat[i], 14'd0);
      total++;
      if (bus.state_out !== st_exp[i]) begin
        bad++;
        $display("FAIL release_seq[%0d]: got %0d want %0d", i, bus.state_out, st_exp[i]);
      end
    end
    repeat (3) send_frame(7'd31, 14'd0);
    total++;
    if (xfer_cmd.size() != n0 + 2 || xfer_cmd[n0+1] != 2) begin
      bad++;
      $display("FAIL rearm_fire: got xfers=%0d want 2", xfer_cmd.size() - n0);
    end
  endtask

  task automatic test_random();
    int plist[10] = '{0, 17, 18, 28, 29, 33, 34, 45, 46, 127};
    int rlist[5]  = '{0, 79, 80, 81, 16383};
    int frames = 0;
    go_idle();
    total++;
    if (bus.state_out !== 2'd0) begin
      bad++;
      $display("FAIL rand_start: got %0d want 0", bus.state_out);
    end
    m_armed = 1'b1; m_run_len = 0; m_none_run = 0;
    while (frames < 300) begin
      int p   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 127)) : plist[$urandom_range(0, 9)];
      int run = $urandom_range(1, 4);
      for (int k = 0; k < run; k++) begin
        int r = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 16383)) : rlist[$urandom_range(0, 4)];
        int c = ref_class(p, r);
        int f = model_frame(c);
        int n0 = xfer_cmd.size();
        send_frame(7'(p), 14'(r));
        frames++;
        total++;
        if (int'(bus.cur_class) != ((c == 4) ? 0 : c)) begin
          bad++;
          $display("FAIL rand_class p=%0d r=%0d: got %0d want %0d", p, r, bus.cur_class, (c == 4) ? 0 : c);
        end
        total++;
        if (xfer_cmd.size() != n0 + ((f >= 0) ? 1 : 0)) begin
          bad++;
          $display("FAIL rand_fire p=%0d: got %0d want %0d", p, xfer_cmd.size() - n0, (f >= 0) ? 1 : 0);
        end else if (f >= 0) begin
          total++;
          if (xfer_cmd[n0] != f) begin
            bad++;
            $display("FAIL rand_cmd: got %0d want %0d", xfer_cmd[n0], f);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int n0;
    go_idle();
    bus.cmd_ready = 1'b0;
    n0 = xfer_cmd.size();
    repeat (3) send_frame(7'd31, 14'd0);
    total++;
    if (bus.cmd_valid !== 1'b1) begin
      bad++;
      $display("FAIL mid_pending: got %b want 1", bus.cmd_valid);
    end
    rst_n = 1'b0;
    @(negedge clk25);
    total++;
    if (bus.cmd_valid !== 1'b0 || bus.state_out !== 2'd0) begin
      bad++;
      $display("FAIL mid_reset: got valid=%b state=%0d want 0 0", bus.cmd_valid, bus.state_out);
    end
    rst_n = 1'b1;
    bus.cmd_ready = 1'b1;
    @(negedge clk25);
    total++;
    if (bus.cmd_valid !== 1'b0 || bus.state_out !== 2'd0 || xfer_cmd.size() != n0) begin
      bad++;
      $display("FAIL mid_after: got valid=%b state=%0d xfers=%0d want 0 0 0", bus.cmd_valid, bus.state_out, xfer_cmd.size() - n0);
    end
  endtask

  initial begin
    bus.vga_vsync = 1'b1;
    bus.pout      = 7'd0;
    bus.ratio     = 14'd0;
    bus.cmd_ready = 1'b0;
    test_reset();
    test_debounce();
    test_next_ratio();
    test_class_change();
    test_backpressure();
    test_invalid_release();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
